// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler (build option: MUX_SCHED_LOCK_EN).
// Latency: none (package only).
// Backpressure: not applicable.
package mux_sched_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux8.sv
// Shared 8:1 single-bit mux tree.
// Latency: purely combinational.
// Backpressure: none.
module mux8 (
    input  logic [7:0] din,
    input  logic [2:0] sel,
    output logic       y
);

    logic [3:0] lvl1;
    logic [1:0] lvl2;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lvl1[k] = sel[0] ? din[2*k+1] : din[2*k];
        end
        for (int k = 0; k < 2; k++) begin
            lvl2[k] = sel[1] ? lvl1[2*k+1] : lvl1[2*k];
        end
        y = sel[2] ? lvl2[1] : lvl2[0];
    end

endmodule

// File: rtl/rr_pick8.sv
// Rotating first-set-bit finder over eight requests, starting at ptr.
// Latency: purely combinational.
// Backpressure: none; the result is valid whenever found is high.
module rr_pick8
    import mux_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     pos;

    // Rotate so that bit 0 of rot is the requester at ptr.
    assign dbl = {req, req};
    assign rot = dbl[ptr +: NUM_REQ];

    always_comb begin
        pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = SEL_W'(k);
            end
        end
    end

    assign found = |req;
    assign idx   = ptr + pos;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin owner of the shared 8:1 mux select, up to BURST cycles per grant (option MUX_SCHED_LOCK_EN).
// Latency: grant registered one edge after the request is sampled; y is combinational from sel and din.
// Backpressure: owner releases by dropping req; lock (when built in) extends a burst past BURST.
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
`ifdef MUX_SCHED_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               y
);

    localparam int             CNT_W   = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST);

    sched_state_t       state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SEL_W-1:0]   pick_ptr;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               owner_req;
    logic               at_max;
    logic               hold_lock;
    logic               release_grant;
    logic               mux_y;

    // While granted, the picker already looks from the slot after the owner so
    // a release can regrant in the same cycle.
    assign pick_ptr = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req = req[sel_q];
    assign at_max    = (cnt_q == CNT_MAX);

`ifdef MUX_SCHED_LOCK_EN
    assign hold_lock = lock[sel_q] & owner_req;
`else
    assign hold_lock = 1'b0;
`endif

    assign release_grant = !owner_req || (at_max && !hold_lock);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot8(pick_idx);
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (release_grant) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (pick_found) begin
                        sel_d = pick_idx;
                        gnt_d = onehot8(pick_idx);
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (!at_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    mux8 u_mux (
        .din (din),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign y    = mux_y & busy_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed and randomized checks of mux_rr_sched against a queue-free owner/burst model.
module tb_mux_rr_sched;

    localparam int BURST = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
`ifdef MUX_SCHED_LOCK_EN
    logic [7:0] lock;
`endif
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       y;

    int n_checks = 0;
    int n_errors = 0;

    mux_rr_sched #(.BURST(BURST)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
`ifdef MUX_SCHED_LOCK_EN
        .lock  (lock),
`endif
        .sel   (sel),
        .gnt   (gnt),
        .busy  (busy),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: current owner (-1 when idle), cycles used, next search start.
    int m_owner, m_last, m_used, m_ptr, m_w;
    bit m_keep, m_locked;

    function automatic int pick(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 0;
            m_used  = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            m_w = pick(req, m_ptr);
            if (m_w >= 0) begin
                m_owner = m_w;
                m_used  = 1;
            end
        end else begin
`ifdef MUX_SCHED_LOCK_EN
            m_locked = lock[m_owner];
`else
            m_locked = 1'b0;
`endif
            m_keep = req[m_owner] && (m_used < BURST || m_locked);
            if (m_keep) begin
                if (m_used < BURST) m_used++;
            end else begin
                m_ptr  = (m_owner + 1) % 8;
                m_last = m_owner;
                m_w    = pick(req, m_ptr);
                if (m_w >= 0) begin
                    m_owner = m_w;
                    m_used  = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
    end

    int e_sel;
    always begin
        @(posedge clk);
        #1;
        e_sel = (m_owner >= 0) ? m_owner : m_last;
        check("model_gnt", gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
        check("model_sel", sel, e_sel);
        check("model_busy", busy, (m_owner >= 0) ? 1 : 0);
        check("model_y", y, (m_owner >= 0) ? din[e_sel] : 0);
    end

    int rot_seq [17] = '{7, 7, 7, 7, 0, 0, 0, 0, 5, 5, 5, 5, 7, 7, 7, 7, 0};

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        din   = 8'hA5;
`ifdef MUX_SCHED_LOCK_EN
        lock  = 8'h00;
`endif
        repeat (2) @(posedge clk);
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_y", y, 0);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #2;
        check("first_sel", sel, 0);
        check("first_gnt", gnt, 8'h01);

        // Single requester keeps the grant across burst boundaries.
        @(negedge clk) req = 8'h20;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            check("hold_gnt", gnt, 8'h20);
            check("hold_busy", busy, 1);
        end

        @(negedge clk) req = 8'h00;
        @(posedge clk);
        @(posedge clk); #2;
        check("idle_gnt", gnt, 0);
        check("idle_busy", busy, 0);
        check("idle_sel", sel, 5);

        // Search restarts at 6 after owner 5 released; rotation wraps 7 -> 0.
        @(negedge clk) req = 8'hA1;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #2;
            check("rot_sel", sel, rot_seq[i]);
        end

        @(negedge clk) req = 8'h08;
        @(posedge clk); #2;
        check("drop_gnt3a", gnt, 8'h08);
        @(posedge clk); #2;
        check("drop_gnt3b", gnt, 8'h08);
        @(negedge clk) req = 8'h02;
        @(posedge clk); #2;
        check("drop_gnt1", gnt, 8'h02);
        check("drop_busy", busy, 1);

        @(negedge clk) req = 8'h40;
        @(posedge clk); #2;
        check("pre_rst_sel", sel, 6);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", gnt, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_sel", sel, 0);
        @(negedge clk);
        req   = 8'h41;
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("post_rst_gnt", gnt, 8'h01);

        // Random phase: requests change on about a third of cycles so bursts complete.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            din = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                req = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom & $urandom);
            end
`ifdef MUX_SCHED_LOCK_EN
            if ($urandom_range(0, 3) == 0) lock = 8'($urandom & $urandom);
`endif
        end

        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
